// File: rtl/addsub_pipe.sv
// -----------------------------------------------------------------------------
// addsub_pipe
// Pipelined adder/subtractor for the DSP slice datapath. An optional input
// register stage feeds a registered result stage that produces the sum or
// difference, a carry/borrow flag and a signed-overflow flag. In accumulate
// mode the current result register replaces the D operand.
//
// Parameters
//   WIDTH    operand/result width in bits (>= 2)
//   INREG    1 = register D/B/CIN/OPMODE/VALID_IN before the adder
//   CARRY_EN 1 = CIN takes part in the arithmetic, 0 = CIN ignored
//
// Ports
//   CLK       rising-edge clock
//   RST       asynchronous active-high reset, clears every register
//   CE        clock enable for every pipeline register
//   CLR       synchronous clear of the result registers (qualified by CE)
//   D, B      operands
//   CIN       carry-in (add) / borrow-in (subtract)
//   OPMODE    [0] 1 = subtract, [1] 1 = accumulate (OUT replaces D)
//   VALID_IN  operands valid this cycle
//   OUT       registered result
//   COUT      registered carry (add) / borrow (subtract)
//   OVF       registered signed overflow
//   VALID_OUT one-cycle flag per completed operation
// -----------------------------------------------------------------------------
module addsub_pipe #(
  parameter int WIDTH    = 18,
  parameter int INREG    = 1,
  parameter int CARRY_EN = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CE,
  input  logic             CLR,
  input  logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  input  logic [1:0]       OPMODE,
  input  logic             VALID_IN,
  output logic [WIDTH-1:0] OUT,
  output logic             COUT,
  output logic             OVF,
  output logic             VALID_OUT
);

  // Signed overflow of a + b: operands agree in sign, result does not.
  function automatic logic add_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  // Signed overflow of a - b: operands differ in sign, result differs from a.
  function automatic logic sub_ovf(input logic a_msb, input logic b_msb,
                                   input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  logic             cin_gated_s;
  logic [WIDTH-1:0] d_s;
  logic [WIDTH-1:0] b_s;
  logic             cin_s;
  logic [1:0]       op_s;
  logic             vld_s;

  logic [WIDTH-1:0] out_r;
  logic             cout_r;
  logic             ovf_r;
  logic             vout_r;

  logic [WIDTH-1:0] a_s;
  logic [WIDTH:0]   res_s;
  logic             ovf_s;

  generate
    if (CARRY_EN != 32'sd0) begin : g_carry
      assign cin_gated_s = CIN;
    end else begin : g_nocarry
      assign cin_gated_s = 1'b0;
    end
  endgenerate

  generate
    if (INREG != 32'sd0) begin : g_inreg
      logic [WIDTH-1:0] d_r;
      logic [WIDTH-1:0] b_r;
      logic             cin_r;
      logic [1:0]       op_r;
      logic             vld_r;

      // Stage-1 operand register; unaffected by CLR.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          d_r   <= {WIDTH{1'b0}};
          b_r   <= {WIDTH{1'b0}};
          cin_r <= 1'b0;
          op_r  <= 2'b00;
          vld_r <= 1'b0;
        end else if (CE) begin
          d_r   <= D;
          b_r   <= B;
          cin_r <= cin_gated_s;
          op_r  <= OPMODE;
          vld_r <= VALID_IN;
        end
      end

      assign d_s   = d_r;
      assign b_s   = b_r;
      assign cin_s = cin_r;
      assign op_s  = op_r;
      assign vld_s = vld_r;
    end else begin : g_noreg
      assign d_s   = D;
      assign b_s   = B;
      assign cin_s = cin_gated_s;
      assign op_s  = OPMODE;
      assign vld_s = VALID_IN;
    end
  endgenerate

  // Adder/subtractor in WIDTH+1 bits; the top bit is carry on add and
  // borrow on subtract (a negative difference sets it).
  always_comb begin
    a_s   = op_s[1] ? out_r : d_s;
    res_s = {(WIDTH+1){1'b0}};
    ovf_s = 1'b0;
    if (op_s[0]) begin
      res_s = {1'b0, a_s} - {1'b0, b_s} - {{WIDTH{1'b0}}, cin_s};
      ovf_s = sub_ovf(a_s[WIDTH-1], b_s[WIDTH-1], res_s[WIDTH-1]);
    end else begin
      res_s = {1'b0, a_s} + {1'b0, b_s} + {{WIDTH{1'b0}}, cin_s};
      ovf_s = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], res_s[WIDTH-1]);
    end
  end

  // Stage-2 result register: CLR wins over a valid operation; an idle
  // slot keeps the result and drops VALID_OUT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      out_r  <= {WIDTH{1'b0}};
      cout_r <= 1'b0;
      ovf_r  <= 1'b0;
      vout_r <= 1'b0;
    end else if (CE) begin
      if (CLR) begin
        out_r  <= {WIDTH{1'b0}};
        cout_r <= 1'b0;
        ovf_r  <= 1'b0;
        vout_r <= 1'b0;
      end else if (vld_s) begin
        out_r  <= res_s[WIDTH-1:0];
        cout_r <= res_s[WIDTH];
        ovf_r  <= ovf_s;
        vout_r <= 1'b1;
      end else begin
        vout_r <= 1'b0;
      end
    end
  end

  assign OUT       = out_r;
  assign COUT      = cout_r;
  assign OVF       = ovf_r;
  assign VALID_OUT = vout_r;

endmodule

// File: doc/addsub_pipe.md
Name: addsub_pipe

Overview:
- Parametrised, pipelined pre/post adder-subtractor for the DSP48A1 slice datapath.
- Generalises the combinational add/subtract unit in four ways:
  - configurable width;
  - optional input register stage;
  - registered result with carry/borrow and signed-overflow flags;
  - accumulate modes that feed the result back as the D operand.
- Sits between the pre-adder/multiplier outputs and the P register path; also usable as a stand-alone post-adder.

Parameters:
- WIDTH, 18, operand and result width in bits (≥2).
- INREG, 1, 1 = register D/B/CIN/OPMODE/VALID_IN before the adder; 0 = adder reads inputs directly.
- CARRY_EN, 1, 1 = CIN participates in arithmetic; 0 = CIN forced to 0 internally.

Ports:
- CLK  input  1  rising-edge clock.
- RST  input  1  asynchronous, active-high reset; clears every register.
- CE  input  1  clock enable for all pipeline registers; low = all registers hold.
- CLR  input  1  synchronous accumulator clear, qualified by CE.
- D  input  WIDTH  first operand (unsigned/two's complement, same bits).
- B  input  WIDTH  second operand.
- CIN  input  1  carry-in (add) / borrow-in (subtract).
- OPMODE  input  2  [0] = 1 subtract, 0 add; [1] = 1 accumulate (OUT replaces D).
- VALID_IN  input  1  operands valid this cycle.
- OUT  output  WIDTH  registered result.
- COUT  output  1  registered carry (add) / borrow (subtract).
- OVF  output  1  registered signed overflow.
- VALID_OUT  output  1  OUT/COUT/OVF updated by a valid operation.

Behaviour:
- Reset: RST high at any time, independent of CLK, clears all outputs and internal registers to 0.
  - Cleared: OUT, COUT, OVF, VALID_OUT, the stage-1 registers and any transaction in flight.
  - First capture is the first rising edge after RST deasserts.
- Pipeline:
  - Stage 1 exists only when INREG=1. It captures D, B, CIN (gated by CARRY_EN), OPMODE and VALID_IN on each CE-high edge.
  - Stage 2 (always present) computes from the stage-1 values, or from the raw inputs when INREG=0, and registers OUT/COUT/OVF/VALID_OUT.
  - Latency, VALID_IN to VALID_OUT: 1+INREG CE-qualified edges.
  - Throughput: one operation per CE-high cycle.
- Operand A: D when OPMODE[1]=0; current OUT register when OPMODE[1]=1.
- Arithmetic, computed in WIDTH+1 bits with c = CIN&CARRY_EN:
  - Add (OPMODE[0]=0): {COUT,OUT} = A + B + c.
  - Subtract (OPMODE[0]=1): OUT = A − B − c, modulo 2^WIDTH. COUT = 1 iff A < B + c as unsigned values (borrow).
- OVF, on the WIDTH-bit results:
  - Add: A and B have the same sign and OUT's sign differs.
  - Subtract: A and B have different signs and OUT's sign differs from A.
- Stage-2 update rule:
  - Results update only when CE=1 and the stage-2 valid bit is 1.
  - If the stage-2 valid bit is 0, OUT/COUT/OVF hold and VALID_OUT goes 0 on that edge.
  - VALID_OUT is a one-cycle flag per completed operation; it stays high on back-to-back operations.
- CLR:
  - With CE=1, CLR forces OUT, COUT and OVF to 0 and VALID_OUT to 0 on that edge.
  - CLR overrides a simultaneous valid operation, which is discarded.
  - Stage-1 contents are unaffected.
- CE low: every register holds, including VALID_OUT. An in-flight operation resumes when CE returns high.
- Wrap-around: no saturation; results wrap modulo 2^WIDTH with COUT/OVF flagging the wrap.
- Accumulate with INREG=1 uses OUT as it stands at the stage-2 edge. Back-to-back accumulate operations therefore chain correctly with no stall.

Test Plan:
- WIDTH=18, INREG=1, CE=1, OPMODE=00, D=0x3FFFF, B=0x00001, CIN=0, VALID_IN pulse → two edges later VALID_OUT=1, OUT=0x00000, COUT=1, OVF=0.
- OPMODE=01, D=0x00005, B=0x00007, CIN=1 → OUT=0x3FFFD, COUT=1 (borrow), OVF=0.
- Signed overflow: OPMODE=00, D=0x1FFFF, B=0x00001 → OUT=0x20000, OVF=1, COUT=0.
  - Then OPMODE=01, D=0x20000, B=0x00001 → OUT=0x1FFFF, OVF=1.
- Accumulate chain:
  - Steps:
    1. CLR pulse.
    2. Four back-to-back operations with OPMODE=10, B=3, 5, 7, 9.
    3. One operation with OPMODE=11, B=4.
  - Expected OUT sequence: 3, 8, 15, 24, 20; VALID_OUT high for all five consecutive cycles.
- CE stall: issue an add (D=10, B=20), then drop CE for 3 cycles after stage 1 captures → OUT/VALID_OUT frozen throughout. On CE high, OUT=30 and VALID_OUT=1 one edge later.
- Reset mid-operation:
  - With INREG=1, assert RST asynchronously between edges while an operation sits in stage 1 → OUT, COUT, OVF and VALID_OUT read 0 immediately.
  - After RST deasserts, no stale VALID_OUT appears.
  - Repeat with INREG=0: latency 1, the same add completes in one edge.
